// File: rtl/audio_sample_streamer.sv
// Streams signed 8-bit audio samples out of packed 32-bit flash words, one per sample tick.
// Each word carries two samples in bytes [15:8] and [31:24]; playback may run forward or reverse.
module audio_sample_streamer #(
  parameter int unsigned        CLK_DIV  = 2273,
  parameter int unsigned        ADDR_W   = 23,
  parameter logic [ADDR_W-1:0]  END_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play,
  input  logic              dir_fwd,
  input  logic              restart,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [7:0]        audio,
  output logic              audio_valid
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitData,
    StFirstWait,
    StFirstOut,
    StSecondWait,
    StSecondOut,
    StNextAddr
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       samp_q, samp_d;  // {byte [31:24], byte [15:8]} of the fetched word
  logic [7:0]        audio_q, audio_d;
  logic              fwd_q, fwd_d;
  logic              pend_q, pend_d;
  logic              tick;
  logic [ADDR_W-1:0] restart_addr;

  // The low byte of each 16-bit half never reaches the output.
  logic unused_rdata;
  assign unused_rdata = ^{flash_readdata[23:16], flash_readdata[7:0]};

  assign tick         = (cnt_q == CntW'(CLK_DIV - 1));
  assign restart_addr = dir_fwd ? '0 : END_ADDR;

  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    state_d     = state_q;
    addr_d      = addr_q;
    samp_d      = samp_q;
    audio_d     = audio_q;
    fwd_d       = fwd_q;
    pend_d      = pend_q | (restart && (state_q != StIdle));
    flash_read  = 1'b0;
    audio_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (restart) addr_d = restart_addr;
        if (play) state_d = StReq;
      end
      StReq: begin
        flash_read = 1'b1;
        if (!flash_waitrequest) state_d = StWaitData;
      end
      StWaitData: begin
        if (flash_readdatavalid) begin
          samp_d  = {flash_readdata[31:24], flash_readdata[15:8]};
          state_d = StFirstWait;
        end
      end
      StFirstWait: begin
        if (tick && play) begin
          // Byte order for the whole word is fixed by the direction seen here.
          fwd_d   = dir_fwd;
          audio_d = dir_fwd ? samp_q[7:0] : samp_q[15:8];
          state_d = StFirstOut;
        end
      end
      StFirstOut: begin
        audio_valid = 1'b1;
        state_d     = StSecondWait;
      end
      StSecondWait: begin
        if (tick && play) begin
          audio_d = fwd_q ? samp_q[15:8] : samp_q[7:0];
          state_d = StSecondOut;
        end
      end
      StSecondOut: begin
        audio_valid = 1'b1;
        state_d     = StNextAddr;
      end
      StNextAddr: begin
        if (pend_q || restart) begin
          addr_d = restart_addr;
          pend_d = 1'b0;
        end else if (dir_fwd) begin
          addr_d = (addr_q == END_ADDR) ? '0 : addr_q + 1'b1;
        end else begin
          addr_d = (addr_q == '0) ? END_ADDR : addr_q - 1'b1;
        end
        state_d = play ? StReq : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      samp_q  <= '0;
      audio_q <= '0;
      fwd_q   <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      samp_q  <= samp_d;
      audio_q <= audio_d;
      fwd_q   <= fwd_d;
      pend_q  <= pend_d;
    end
  end

  assign flash_address = addr_q;
  assign audio         = audio_q;

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Bench for audio_sample_streamer: flash responder, event-level reference model with a
// per-cycle compare, directed scenarios with literal expectations, then randomized play.
module tb_audio_sample_streamer;

  localparam int unsigned       CLK_DIV  = 4;
  localparam int unsigned       ADDR_W   = 23;
  localparam logic [ADDR_W-1:0] END_ADDR = 23'd3;

  logic              clk = 1'b0;
  logic              reset_n, play, dir_fwd, restart;
  logic              flash_read, flash_waitrequest, flash_readdatavalid;
  logic [ADDR_W-1:0] flash_address;
  logic [31:0]       flash_readdata;
  logic [7:0]        audio;
  logic              audio_valid;

  always #5 clk = ~clk;

  audio_sample_streamer #(
    .CLK_DIV  (CLK_DIV),
    .ADDR_W   (ADDR_W),
    .END_ADDR (END_ADDR)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .play                (play),
    .dir_fwd             (dir_fwd),
    .restart             (restart),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .audio               (audio),
    .audio_valid         (audio_valid)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Flash responder: one outstanding read, configurable stall and latency.
  logic [31:0]       mem [4];
  int                wr_mode    = 0;  // 0 never stall, 1 random stall, 2 always stall
  int                fl_lat_min = 0;
  int                fl_lat_max = 0;
  bit                fl_busy    = 1'b0;
  int                fl_cnt     = 0;
  logic [ADDR_W-1:0] fl_addr    = '0;
  int                acc_count  = 0;
  logic [ADDR_W-1:0] last_acc_addr = '0;

  initial begin : flash_model
    flash_waitrequest   = 1'b0;
    flash_readdatavalid = 1'b0;
    flash_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      flash_readdatavalid = 1'b0;
      flash_readdata      = $urandom();
      if (fl_busy) begin
        if (fl_cnt == 0) begin
          flash_readdatavalid = 1'b1;
          flash_readdata      = mem[fl_addr[1:0]];
          fl_busy             = 1'b0;
        end else begin
          fl_cnt--;
        end
      end
      case (wr_mode)
        0:       flash_waitrequest = 1'b0;
        1:       flash_waitrequest = ($urandom_range(3, 0) == 0);
        default: flash_waitrequest = 1'b1;
      endcase
      @(negedge clk);
      if (flash_read && !flash_waitrequest) begin
        fl_busy       = 1'b1;
        fl_cnt        = $urandom_range(fl_lat_max, fl_lat_min);
        fl_addr       = flash_address;
        last_acc_addr = flash_address;
        acc_count++;
      end
    end
  end

  // Reference model: tracks the word in flight as events (request owed, data owed,
  // bytes left, earliest cycle a tick may be consumed) and the cycle of each strobe.
  int                k = 0;
  bit                m_live = 1'b0;
  bit                m_idle, m_req, m_wait, m_pend, m_fwd;
  int                m_left, m_elig, m_next_at, m_strobe_at, tcnt;
  logic [31:0]       m_word;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_audio;
  logic [7:0]        s_log [$];
  int                s_cyc [$];

  always @(negedge clk) begin : compare
    bit tick, idle_now, at_next;
    k++;
    if (m_live) begin
      chk("audio_valid", audio_valid, (k == m_strobe_at));
      chk("audio", audio, m_audio);
      chk("flash_read", flash_read, m_req);
      chk("flash_address", flash_address, m_addr);
      if (audio_valid === 1'b1) begin
        s_log.push_back(audio);
        s_cyc.push_back(k);
      end
    end
    if (reset_n === 1'b0) begin
      m_live = 1'b1; m_idle = 1'b1; m_req = 1'b0; m_wait = 1'b0; m_pend = 1'b0; m_fwd = 1'b1;
      m_left = 0; m_elig = 0; m_next_at = -1; m_strobe_at = -1; tcnt = 0;
      m_addr = '0; m_audio = '0; m_word = '0;
    end else if (m_live) begin
      tick     = (tcnt == CLK_DIV - 1);
      at_next  = (k == m_next_at);
      idle_now = m_idle;
      if (restart && !idle_now && !at_next) m_pend = 1'b1;
      if (m_req) begin
        if (!flash_waitrequest) begin
          m_req  = 1'b0;
          m_wait = 1'b1;
        end
      end else if (m_wait) begin
        if (flash_readdatavalid) begin
          m_wait = 1'b0;
          m_word = flash_readdata;
          m_left = 2;
          m_elig = k + 1;
        end
      end else if (m_left > 0) begin
        if (k >= m_elig && tick && play) begin
          if (m_left == 2) begin
            m_fwd   = dir_fwd;
            m_audio = dir_fwd ? m_word[15:8] : m_word[31:24];
          end else begin
            m_audio = m_fwd ? m_word[31:24] : m_word[15:8];
          end
          m_left--;
          m_strobe_at = k + 1;
          m_elig      = k + 2;
          if (m_left == 0) m_next_at = k + 2;
        end
      end else if (at_next) begin
        if (m_pend || restart) begin
          m_addr = dir_fwd ? '0 : END_ADDR;
          m_pend = 1'b0;
        end else if (dir_fwd) begin
          m_addr = ADDR_W'((int'(m_addr) + 1) % (int'(END_ADDR) + 1));
        end else begin
          m_addr = ADDR_W'((int'(m_addr) + int'(END_ADDR)) % (int'(END_ADDR) + 1));
        end
        if (play) m_req = 1'b1;
        else      m_idle = 1'b1;
      end else if (idle_now) begin
        if (restart) m_addr = dir_fwd ? '0 : END_ADDR;
        if (play) begin
          m_idle = 1'b0;
          m_req  = 1'b1;
        end
      end
      tcnt = tick ? 0 : tcnt + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
  endtask

  task automatic wait_strobes(input int n, input string name);
    int b;
    b = 0;
    while (s_log.size() < n && b < 400) begin
      cyc(1);
      b++;
    end
    chk(name, (s_log.size() >= n), 1'b1);
  endtask

  task automatic wait_acc(input int n, input string name);
    int b;
    b = 0;
    while (acc_count < n && b < 400) begin
      cyc(1);
      b++;
    end
    chk(name, (acc_count >= n), 1'b1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, base_acc, rd_hi, bad;
    reset_n = 1'b0; play = 1'b0; dir_fwd = 1'b1; restart = 1'b0;
    mem[0] = 32'h80FF_7F01; mem[1] = 32'h1122_3344;
    mem[2] = 32'h9A8B_7C6D; mem[3] = 32'h5566_7788;
    cyc(3);
    reset_n = 1'b1;

    // Forward stream of words 0 and 1, zero-latency flash.
    do_reset();
    chk("reset_audio", audio, 8'h00);
    chk("reset_valid", audio_valid, 1'b0);
    chk("reset_read", flash_read, 1'b0);
    chk("reset_addr", flash_address, '0);
    base = s_log.size();
    play = 1'b1;
    wait_strobes(base + 2, "t1_wait2");
    cyc(2);
    chk("t1_addr1", flash_address, 23'd1);
    wait_strobes(base + 4, "t1_wait4");
    cyc(2);
    chk("t1_addr2", flash_address, 23'd2);
    if (s_log.size() >= base + 4) begin
      chk("t1_b0", s_log[base], 8'h7F);
      chk("t1_b1", s_log[base+1], 8'h80);
      chk("t1_b2", s_log[base+2], 8'h33);
      chk("t1_b3", s_log[base+3], 8'h11);
      chk("t1_gap_in_word0", s_cyc[base+1] - s_cyc[base], CLK_DIV);
      chk("t1_gap_in_word1", s_cyc[base+3] - s_cyc[base+2], CLK_DIV);
      chk("t1_gap_across", s_cyc[base+2] - s_cyc[base+1], 2 * CLK_DIV);
    end

    // Flash stalls ten cycles in REQ.
    play = 1'b0;
    do_reset();
    wr_mode  = 2;
    base     = s_log.size();
    base_acc = acc_count;
    play     = 1'b1;
    cyc(1);
    rd_hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (flash_read === 1'b1 && flash_address === '0) rd_hi++;
      cyc(1);
    end
    chk("t2_read_held", rd_hi, 10);
    chk("t2_no_accept", acc_count - base_acc, 0);
    chk("t2_no_strobe", s_log.size() - base, 0);
    wr_mode = 0;
    wait_strobes(base + 1, "t2_wait1");
    chk("t2_one_accept", acc_count - base_acc, 1);

    // Reverse from address 0 wraps down to END_ADDR.
    play    = 1'b0;
    dir_fwd = 1'b0;
    mem[0]  = 32'hA1B2_C3D4;
    do_reset();
    base = s_log.size();
    play = 1'b1;
    wait_strobes(base + 2, "t3_wait2");
    cyc(2);
    chk("t3_addr3", flash_address, 23'd3);
    wait_strobes(base + 4, "t3_wait4");
    cyc(2);
    chk("t3_addr2", flash_address, 23'd2);
    if (s_log.size() >= base + 4) begin
      chk("t3_b0", s_log[base], 8'hA1);
      chk("t3_b1", s_log[base+1], 8'hC3);
      chk("t3_b2", s_log[base+2], 8'h55);
      chk("t3_b3", s_log[base+3], 8'h77);
    end

    // Idle restart loads END_ADDR, then forward playback wraps 3 -> 0.
    play    = 1'b0;
    dir_fwd = 1'b1;
    do_reset();
    dir_fwd = 1'b0;
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    dir_fwd = 1'b1;
    cyc(1);
    chk("t4_idle_restart", flash_address, 23'd3);
    base = s_log.size();
    play = 1'b1;
    wait_strobes(base + 2, "t4_wait2");
    cyc(2);
    chk("t4_wrap", flash_address, 23'd0);
    if (s_log.size() >= base + 2) begin
      chk("t4_b0", s_log[base], 8'h77);
      chk("t4_b1", s_log[base+1], 8'h55);
    end

    // Pause after the first byte of a word, then resume.
    play = 1'b0;
    do_reset();
    base = s_log.size();
    play = 1'b1;
    wait_strobes(base + 1, "t5_wait1");
    play = 1'b0;
    bad  = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (audio !== 8'hC3 || audio_valid !== 1'b0) bad++;
    end
    chk("t5_hold", bad, 0);
    chk("t5_no_strobe", s_log.size() - base, 1);
    play = 1'b1;
    wait_strobes(base + 2, "t5_wait2");
    if (s_log.size() >= base + 2) chk("t5_resume_byte", s_log[base+1], 8'hA1);

    // Restart during WAIT_DATA of word 2 lets the word finish, then jumps to 0.
    play       = 1'b0;
    fl_lat_min = 5;
    fl_lat_max = 5;
    do_reset();
    base     = s_log.size();
    base_acc = acc_count;
    play     = 1'b1;
    wait_acc(base_acc + 3, "t6_wait_acc3");
    chk("t6_acc_addr2", last_acc_addr, 23'd2);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    wait_strobes(base + 6, "t6_wait6");
    if (s_log.size() >= base + 6) begin
      chk("t6_b0", s_log[base+4], 8'h7C);
      chk("t6_b1", s_log[base+5], 8'h9A);
    end
    wait_acc(base_acc + 4, "t6_wait_acc4");
    chk("t6_jump_addr", last_acc_addr, 23'd0);

    // Reset while waiting for data; the late readdatavalid must be ignored.
    wait_acc(acc_count + 1, "t7_wait_acc");
    reset_n = 1'b0;
    play    = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    chk("t7_audio", audio, 8'h00);
    chk("t7_read", flash_read, 1'b0);
    base = s_log.size();
    cyc(8);
    chk("t7_no_strobe", s_log.size() - base, 0);
    chk("t7_read_after", flash_read, 1'b0);
    chk("t7_audio_after", audio, 8'h00);

    // Randomized play/direction/restart against the model.
    for (int i = 0; i < 4; i++) mem[i] = $urandom();
    fl_lat_min = 0;
    fl_lat_max = 3;
    wr_mode    = 1;
    do_reset();
    base = s_log.size();
    for (int i = 0; i < 3000; i++) begin
      play = ($urandom_range(9, 0) != 0);
      if ($urandom_range(49, 0) == 0) dir_fwd = ~dir_fwd;
      restart = ($urandom_range(99, 0) == 0);
      cyc(1);
    end
    play    = 1'b0;
    restart = 1'b0;
    cyc(2);
    chk("rand_progress", (s_log.size() - base > 50), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
